// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Flag outputs exist only when SERIAL_SUBTRACTOR_FLAGS_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic             zr;
    logic             ng;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zr, ng, ovf
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zr, ng, ovf
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b, LSB first, DIGIT bits per clock, valid/ready on both sides.
// Optional zr/ng/ovf flag outputs are built when SERIAL_SUBTRACTOR_FLAGS_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst_n,
    serial_subtractor_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("serial_subtractor: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               in_ready_c;
    logic               out_valid_c;
    logic               last_digit;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_nxt;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT:0]     dsub;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;

    // One digit of a - b - borrow_in; the extra top bit is the borrow out.
    function automatic logic [DIGIT:0] digit_sub(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             bin);
        return {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    endfunction

    assign dsub       = digit_sub(a_sr[DIGIT-1:0], b_sr[DIGIT-1:0], br);
    assign res_nxt    = (res_sr >> DIGIT) | (WIDTH'(dsub[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last_digit = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift out LSB first; result digits enter at the MSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_nxt;
            br     <= dsub[DIGIT];
            cnt    <= cnt + CNT_W'(1);
            if (last_digit) begin
                diff_q   <= res_nxt;
                borrow_q <= dsub[DIGIT];
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic a_msb;
    logic b_msb;
    logic zr_q;
    logic ng_q;
    logic ovf_q;

    // Operand signs are captured at accept because the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
        end else if ((state == RUN) && last_digit) begin
            zr_q  <= (res_nxt == '0);
            ng_q  <= res_nxt[WIDTH-1];
            ovf_q <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
        end
    end

    assign bus.zr  = zr_q;
    assign bus.ng  = ng_q;
    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: DIGIT=1 and DIGIT=4 instances, directed vectors.
module tb_serial_subtractor;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus1();
    serial_subtractor_if #(.WIDTH(W)) bus4();

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zr;
        logic         ng;
        logic         ovf;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1;
    exp_t e4;
    int   checks = 0;
    int   errors = 0;

    task automatic fail_line(input string name, input int act, input int req);
        errors++;
        $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) fail_line(name, int'(act), int'(req));
    endtask

    task automatic chk16(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) fail_line(name, int'(act), int'(req));
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) fail_line(name, act, req);
    endtask

    // Monitors: pop one expectation per completed output handshake.
    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                fail_line("sb1_unexpected_result", int'(bus1.diff), 0);
            end else begin
                e1 = q1.pop_front();
                chk16("sb1_diff", bus1.diff, e1.diff);
                chk1("sb1_borrow", bus1.borrow, e1.borrow);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                chk1("sb1_zr", bus1.zr, e1.zr);
                chk1("sb1_ng", bus1.ng, e1.ng);
                chk1("sb1_ovf", bus1.ovf, e1.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                fail_line("sb4_unexpected_result", int'(bus4.diff), 0);
            end else begin
                e4 = q4.pop_front();
                chk16("sb4_diff", bus4.diff, e4.diff);
                chk1("sb4_borrow", bus4.borrow, e4.borrow);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                chk1("sb4_zr", bus4.zr, e4.zr);
                chk1("sb4_ng", bus4.ng, e4.ng);
                chk1("sb4_ovf", bus4.ovf, e4.ovf);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Called at posedge+1; returns the time of the accept edge.
    task automatic send1(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic bo,
                         input logic zr, input logic ng, input logic ovf,
                         input logic push, output time t_acc);
        int k = 0;
        while (!bus1.in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            fail_line("send1_in_ready_timeout", k, 0);
        end
        bus1.in_valid = 1'b1;
        bus1.a = a;
        bus1.b = b;
        if (push) q1.push_back('{d, bo, zr, ng, ovf});
        @(posedge clk);
        t_acc = $time;
        #1;
        bus1.in_valid = 1'b0;
        bus1.a = 16'($urandom);
        bus1.b = 16'($urandom);
    endtask

    task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic bo,
                         input logic zr, input logic ng, input logic ovf);
        int k = 0;
        while (!bus4.in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            fail_line("send4_in_ready_timeout", k, 0);
        end
        bus4.in_valid = 1'b1;
        bus4.a = a;
        bus4.b = b;
        q4.push_back('{d, bo, zr, ng, ovf});
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus4.a = 16'($urandom);
        bus4.b = 16'($urandom);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((q1.size() != 0 || q4.size() != 0) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            fail_line(name, q1.size() + q4.size(), 0);
        end
    endtask

    initial begin
        time t0, ta, tb;
        int  lat;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_in_ready", bus1.in_ready, 1'b1);
        chk1("rst_out_valid", bus1.out_valid, 1'b0);
        chk16("rst_diff", bus1.diff, 16'h0000);
        chk1("rst_borrow", bus1.borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        chk1("rst_zr", bus1.zr, 1'b0);
        chk1("rst_ng", bus1.ng, 1'b0);
        chk1("rst_ovf", bus1.ovf, 1'b0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: out_valid appears exactly 16 edges after accept.
        send1(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        chk1("run_in_ready_low", bus1.in_ready, 1'b0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus1.out_valid) begin
                lat = k;
                break;
            end
        end
        chki("latency_digit1", lat, 16);
        chk1("done_in_ready_low", bus1.in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("idle_in_ready_back", bus1.in_ready, 1'b1);
        chk1("idle_out_valid_low", bus1.out_valid, 1'b0);
        chk16("idle_diff_held", bus1.diff, 16'h0002);

        // Back-to-back transactions: N+2 cycles apart.
        send1(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ta);
        send1(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, tb);
        chki("throughput_cycles", int'((tb - ta) / 10), 18);
        send1(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
        drain("drain_basic");

        // Backpressure: result held in DONE while inputs wiggle.
        bus1.out_ready = 1'b0;
        send1(16'h7000, 16'h9000, 16'hE000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, t0);
        lat = 0;
        while (!bus1.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk1("bp_reached_done", bus1.out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus1.in_valid = ~i[0];
            bus1.a = 16'($urandom);
            bus1.b = 16'($urandom);
            @(posedge clk); #1;
            chk1("bp_out_valid", bus1.out_valid, 1'b1);
            chk1("bp_in_ready", bus1.in_ready, 1'b0);
            chk16("bp_diff", bus1.diff, 16'hE000);
            chk1("bp_borrow", bus1.borrow, 1'b1);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            chk1("bp_ng", bus1.ng, 1'b1);
            chk1("bp_ovf", bus1.ovf, 1'b1);
`endif
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("bp_released", bus1.out_valid, 1'b0);
        chk1("bp_idle_ready", bus1.in_ready, 1'b1);
        drain("drain_bp");

        // DIGIT=4 instance.
        send4(16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b0, 1'b0, 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus4.out_valid) begin
                lat = k;
                break;
            end
        end
        chki("latency_digit4", lat, 4);
        send4(16'h0003, 16'h0007, 16'hFFFC, 1'b1, 1'b0, 1'b1, 1'b0);
        drain("drain_digit4");

        // Asynchronous reset in the middle of RUN discards the partial result.
        send1(16'h4444, 16'h1111, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_out_valid", bus1.out_valid, 1'b0);
        chk1("arst_in_ready", bus1.in_ready, 1'b1);
        chk16("arst_diff", bus1.diff, 16'h0000);
        chk1("arst_borrow", bus1.borrow, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send1(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t0);
        drain("drain_after_reset");
        repeat (4) @(posedge clk);
        #1;
        chk1("final_idle", bus1.in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
